// File: rtl/if_stage.sv
// if_stage: instruction fetch stage with PC register and IF/ID pipeline register.
// The instruction memory read is combinational, so a word fetched at PC lands in
// IF/ID on the next rising edge. Next-PC priority is reset, then branch, then
// freeze, then sequential PC+4.
// Optional build macro IF_STAGE_PERF_CNT_EN adds the fetch_count and
// stall_count performance counter outputs.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_address,
  output logic [31:0] inst_mem_addr,
  input  logic [31:0] inst_mem_data,
  output logic [31:0] pc_out,
  output logic [31:0] instruction,
  output logic        valid
`ifdef IF_STAGE_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] branch_target;
  logic [31:0] pc_next;
  logic [31:0] instruction_next;
  logic [31:0] pc_out_next;
  logic        valid_next;

  assign inst_mem_addr = pc;
  assign pc_plus4      = pc + 32'd4;
  // Word-align the target by masking; keeps every bit of the input in use.
  assign branch_target = branch_address & 32'hFFFF_FFFC;

  // Select next PC and IF/ID contents: branch flushes, freeze holds, else fetch.
  always_comb begin
    pc_next          = pc_plus4;
    instruction_next = inst_mem_data;
    pc_out_next      = pc_plus4;
    valid_next       = 1'b1;
    if (branch_taken) begin
      pc_next          = branch_target;
      instruction_next = 32'h0000_0000;
      pc_out_next      = 32'h0000_0000;
      valid_next       = 1'b0;
    end else if (freeze) begin
      pc_next          = pc;
      instruction_next = instruction;
      pc_out_next      = pc_out;
      valid_next       = valid;
    end
  end

  // PC and IF/ID register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC_ALIGNED;
      instruction <= 32'h0000_0000;
      pc_out      <= 32'h0000_0000;
      valid       <= 1'b0;
    end else begin
      pc          <= pc_next;
      instruction <= instruction_next;
      pc_out      <= pc_out_next;
      valid       <= valid_next;
    end
  end

`ifdef IF_STAGE_PERF_CNT_EN
  logic fetch_cycle;
  logic stall_cycle;

  assign fetch_cycle = ~branch_taken & ~freeze;
  assign stall_cycle = ~branch_taken & freeze;

  // Count sequential fetches and held cycles; both wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count <= 32'd0;
      stall_count <= 32'd0;
    end else begin
      if (fetch_cycle) fetch_count <= fetch_count + 32'd1;
      if (stall_cycle) stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed bench for if_stage. Instruction memory returns
// word[n] = n + 100 for byte address 4n. A second instance with
// RESET_PC = 32'hFFFF_FFFC exercises PC wraparound.
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_address;

  logic [31:0] addr, data, pc_out, instruction;
  logic        valid;
  logic [31:0] w_addr, w_data, w_pc_out, w_instruction;
  logic        w_valid;
`ifdef IF_STAGE_PERF_CNT_EN
  logic [31:0] fetch_count, stall_count, w_fetch_count, w_stall_count;
`endif

  int total = 0;
  int bad   = 0;

  assign data   = (addr >> 2) + 32'd100;
  assign w_data = (w_addr >> 2) + 32'd100;

  if_stage u_dut (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
    .branch_address(branch_address), .inst_mem_addr(addr), .inst_mem_data(data),
    .pc_out(pc_out), .instruction(instruction), .valid(valid)
`ifdef IF_STAGE_PERF_CNT_EN
    , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
    .branch_address(branch_address), .inst_mem_addr(w_addr), .inst_mem_data(w_data),
    .pc_out(w_pc_out), .instruction(w_instruction), .valid(w_valid)
`ifdef IF_STAGE_PERF_CNT_EN
    , .fetch_count(w_fetch_count), .stall_count(w_stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_address = 32'h0;
    step();
    rst = 1'b0;
    total++; if (addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=%h", addr, 32'h0); end
    total++; if (instruction !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h exp=%h", instruction, 32'h0); end
    total++; if (pc_out !== 32'h0) begin bad++; $display("FAIL reset_pc_out got=%h exp=%h", pc_out, 32'h0); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid); end
  endtask

  task automatic test_free_run();
    logic [31:0] exp_instr [4] = '{32'd100, 32'd101, 32'd102, 32'd103};
    logic [31:0] exp_pc    [4] = '{32'd4, 32'd8, 32'd12, 32'd16};
    for (int k = 0; k < 4; k++) begin
      step();
      total++; if (instruction !== exp_instr[k]) begin bad++; $display("FAIL run_instr[%0d] got=%0d exp=%0d", k, instruction, exp_instr[k]); end
      total++; if (pc_out !== exp_pc[k]) begin bad++; $display("FAIL run_pc_out[%0d] got=%0d exp=%0d", k, pc_out, exp_pc[k]); end
      total++; if (valid !== 1'b1) begin bad++; $display("FAIL run_valid[%0d] got=%b exp=1", k, valid); end
      total++; if (addr !== exp_pc[k]) begin bad++; $display("FAIL run_addr[%0d] got=%0d exp=%0d", k, addr, exp_pc[k]); end
    end
  endtask

  task automatic test_freeze();
    rst = 1'b1; step(); rst = 1'b0;
    step(); step();
    freeze = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      total++; if (addr !== 32'd8) begin bad++; $display("FAIL frz_addr[%0d] got=%0d exp=8", k, addr); end
      total++; if (instruction !== 32'd101) begin bad++; $display("FAIL frz_instr[%0d] got=%0d exp=101", k, instruction); end
      total++; if (pc_out !== 32'd8) begin bad++; $display("FAIL frz_pc_out[%0d] got=%0d exp=8", k, pc_out); end
      total++; if (valid !== 1'b1) begin bad++; $display("FAIL frz_valid[%0d] got=%b exp=1", k, valid); end
    end
    freeze = 1'b0;
    step();
    total++; if (instruction !== 32'd102) begin bad++; $display("FAIL rel_instr got=%0d exp=102", instruction); end
    total++; if (pc_out !== 32'd12) begin bad++; $display("FAIL rel_pc_out got=%0d exp=12", pc_out); end
    total++; if (addr !== 32'd12) begin bad++; $display("FAIL rel_addr got=%0d exp=12", addr); end
  endtask

  task automatic test_branch();
    branch_taken = 1'b1; branch_address = 32'h0000_00BE;
    step();
    branch_taken = 1'b0;
    total++; if (addr !== 32'hBC) begin bad++; $display("FAIL br_addr got=%h exp=%h", addr, 32'hBC); end
    total++; if (instruction !== 32'h0) begin bad++; $display("FAIL br_instr got=%h exp=0", instruction); end
    total++; if (pc_out !== 32'h0) begin bad++; $display("FAIL br_pc_out got=%h exp=0", pc_out); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL br_valid got=%b exp=0", valid); end
    step();
    total++; if (instruction !== 32'd147) begin bad++; $display("FAIL br_next_instr got=%0d exp=147", instruction); end
    total++; if (pc_out !== 32'hC0) begin bad++; $display("FAIL br_next_pc_out got=%h exp=%h", pc_out, 32'hC0); end
    total++; if (valid !== 1'b1) begin bad++; $display("FAIL br_next_valid got=%b exp=1", valid); end
  endtask

  task automatic test_branch_freeze();
    branch_taken = 1'b1; freeze = 1'b1; branch_address = 32'h40;
    step();
    branch_taken = 1'b0; freeze = 1'b0;
    total++; if (addr !== 32'h40) begin bad++; $display("FAIL bf_addr got=%h exp=%h", addr, 32'h40); end
    total++; if (instruction !== 32'h0) begin bad++; $display("FAIL bf_instr got=%h exp=0", instruction); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL bf_valid got=%b exp=0", valid); end
    step();
    total++; if (instruction !== 32'd116) begin bad++; $display("FAIL bf_next_instr got=%0d exp=116", instruction); end
    total++; if (pc_out !== 32'h44) begin bad++; $display("FAIL bf_next_pc_out got=%h exp=%h", pc_out, 32'h44); end
  endtask

  task automatic test_back_to_back();
    branch_taken = 1'b1; branch_address = 32'h100;
    step();
    total++; if (addr !== 32'h100) begin bad++; $display("FAIL b2b_addr0 got=%h exp=%h", addr, 32'h100); end
    branch_address = 32'h203;
    step();
    branch_taken = 1'b0;
    total++; if (addr !== 32'h200) begin bad++; $display("FAIL b2b_addr1 got=%h exp=%h", addr, 32'h200); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL b2b_valid got=%b exp=0", valid); end
    total++; if (instruction !== 32'h0) begin bad++; $display("FAIL b2b_instr got=%h exp=0", instruction); end
    freeze = 1'b1;
    step();
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL frz_bubble_valid got=%b exp=0", valid); end
    total++; if (addr !== 32'h200) begin bad++; $display("FAIL frz_bubble_addr got=%h exp=%h", addr, 32'h200); end
    rst = 1'b1;
    step();
    rst = 1'b0; freeze = 1'b0;
    total++; if (addr !== 32'h0) begin bad++; $display("FAIL rst_mid_frz_addr got=%h exp=0", addr); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL rst_mid_frz_valid got=%b exp=0", valid); end
    step();
    total++; if (instruction !== 32'd100) begin bad++; $display("FAIL rst_first_instr got=%0d exp=100", instruction); end
    total++; if (pc_out !== 32'd4) begin bad++; $display("FAIL rst_first_pc_out got=%0d exp=4", pc_out); end
  endtask

  task automatic test_wrap();
    rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0;
    step();
    rst = 1'b0;
    total++; if (w_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_reset_addr got=%h exp=%h", w_addr, 32'hFFFF_FFFC); end
    total++; if (w_valid !== 1'b0) begin bad++; $display("FAIL wrap_reset_valid got=%b exp=0", w_valid); end
    step();
    total++; if (w_addr !== 32'h0) begin bad++; $display("FAIL wrap_addr got=%h exp=0", w_addr); end
    total++; if (w_instruction !== 32'h4000_0063) begin bad++; $display("FAIL wrap_instr got=%h exp=%h", w_instruction, 32'h4000_0063); end
    total++; if (w_pc_out !== 32'h0) begin bad++; $display("FAIL wrap_pc_out got=%h exp=0", w_pc_out); end
    total++; if (w_valid !== 1'b1) begin bad++; $display("FAIL wrap_valid got=%b exp=1", w_valid); end
    freeze = 1'b1;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; freeze = 1'b0;
    total++; if (w_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_rst_frz_addr got=%h exp=%h", w_addr, 32'hFFFF_FFFC); end
    total++; if (w_valid !== 1'b0) begin bad++; $display("FAIL wrap_rst_frz_valid got=%b exp=0", w_valid); end
  endtask

`ifdef IF_STAGE_PERF_CNT_EN
  task automatic test_perf_cnt();
    rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0;
    step();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) step();
    freeze = 1'b1;
    step(); step();
    freeze = 1'b0;
    branch_taken = 1'b1; branch_address = 32'h80;
    step();
    branch_taken = 1'b0;
    total++; if (fetch_count !== 32'd5) begin bad++; $display("FAIL perf_fetch got=%0d exp=5", fetch_count); end
    total++; if (stall_count !== 32'd2) begin bad++; $display("FAIL perf_stall got=%0d exp=2", stall_count); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (fetch_count !== 32'd0) begin bad++; $display("FAIL perf_fetch_rst got=%0d exp=0", fetch_count); end
    total++; if (stall_count !== 32'd0) begin bad++; $display("FAIL perf_stall_rst got=%0d exp=0", stall_count); end
  endtask
`endif

  initial begin
    rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_address = 32'h0;
    #2;
    test_reset();
    test_free_run();
    test_freeze();
    test_branch();
    test_branch_freeze();
    test_back_to_back();
    test_wrap();
`ifdef IF_STAGE_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
